fb_sdram_reader: RTL
====================

// Module: fb_sdram_reader
// PURPOSE
// - Wishbone master on the SDRAM bus (sys_clk domain).
// - Reads the framebuffer linearly, one 32-bit pixel word per transfer, and pushes each word into the
//   write side of the video pixel FIFO.
// - The pixel-clock display stage drains that FIFO.
// - Fetching is throttled by the FIFO almost-full flag and realigned to frame start by a restart pulse.
// PARAMETERS
// - HDISP     800   active pixels per line
// - VDISP     480   active lines per frame
// - BASE_ADR  0     byte address of pixel (0,0); 4-byte aligned
// - BURST_LEN 16    max words per burst (WSHB_BURST_EN only); power of 2, >=2
// PORTS
// - sys_clk       in   1   system clock, 100 MHz
// - sys_rst       in   1   asynchronous, active-high reset
// - frame_restart in   1   1-cycle pulse, sys_clk domain: restart fetch at BASE_ADR
// - wfifo_afull   in   1   pixel FIFO almost full
// - wfifo_write   out  1   FIFO push strobe, 1 cycle per word
// - wfifo_data    out  32  pixel word pushed
// - wb_cyc        out  1   Wishbone cycle
// - wb_stb        out  1   Wishbone strobe
// - wb_we         out  1   constant 0 (read only)
// - wb_adr        out  32  byte address
// - wb_sel        out  4   constant 4'hF
// - wb_cti        out  3   cycle type
// - wb_bte        out  2   constant 2'b00
// - wb_dat_sm     in   32  read data
// - wb_ack        in   1   transfer acknowledge
// - wb_err        in   1   transfer error
// - wb_rty        in   1   retry request
// - frame_done    out  1   1-cycle pulse when the last word of a frame is pushed
// BEHAVIOUR
// - Reset values:
//   - cyc=stb=0, adr=BASE_ADR, cti=0.
//   - wfifo_write=0, wfifo_data=0, frame_done=0.
//   - pixel counter=0, restart_pend=0, state=IDLE.
// - IDLE:
//   - cyc=stb=0.
//   - If restart_pend or frame_restart: adr<=BASE_ADR, counter<=0, pend<=0.
//   - Go to READ the next cycle when wfifo_afull=0.
// - READ:
//   - cyc=stb=1; adr is held stable until a termination (ack, err or rty).
//   - ack: wfifo_write<=1 and wfifo_data<=wb_dat_sm in the next cycle (1-cycle push latency).
//     - Then adr+=4, counter+=1.
//   - err: same as ack, but wfifo_data<=32'h0 (word slot preserved, display stays aligned).
//   - rty: no push, no address change; stb stays high (retry).
//   - ack or err and rty at the same time: ack/err wins.
//   - Leave READ for IDLE (cyc/stb drop the cycle after the termination) if, in the termination cycle:
//     - wfifo_afull=1, or
//     - restart_pend=1 or frame_restart=1.
//   - Without a termination, stb is never dropped; afull and restart are only acted on at a termination.
// - Frame wrap:
//   - On the termination of word HDISP*VDISP-1: adr<=BASE_ADR, counter<=0.
//   - frame_done pulses together with that word's wfifo_write.
// - frame_restart during READ: latched in restart_pend and applied once the in-flight transfer terminates.
//   - The terminating word is still pushed.
// - Restart coinciding with the frame-end word: pend is still applied; the result is identical (BASE_ADR).
// - Counter width: $clog2(HDISP*VDISP).
// - Address arithmetic: 32-bit modulo; no other wrap.
// - sys_rst mid-transfer: immediate return to reset values; the FIFO is reset by the same sys_rst.
// CONFIGURATION
// - WSHB_BURST_EN defined:
//   - READ issues incrementing bursts: cti=3'b010, bte=2'b00.
//   - cti=3'b111 on the last word of a burst. A burst ends after BURST_LEN words, at frame end,
//     or at the first word issued after wfifo_afull or restart is seen.
//   - Bursts never cross the frame end.
//   - The slave may insert wait states; adr advances only on ack/err.
// - WSHB_BURST_EN undefined:
//   - cti=3'b000 always (classic cycles), with the same cyc/stb protocol.
//   - No BURST_LEN logic.
// TESTING
// (HDISP=4, VDISP=2, BASE_ADR=32'h100, slave acks every cycle, data = address)
// - Reset, afull=0:
//   - first stb at adr 0x100.
//   - 8 pushes 0x100..0x11C.
//   - frame_done with the 0x11C push.
//   - next adr 0x100.
// - afull=1 during the 3rd ack:
//   - 3 pushes, then cyc=0.
//   - Resumes at 0x10C after afull=0.
// - frame_restart pulse while stb is high at 0x108 with ack delayed 3 cycles:
//   - 0x108 is pushed, cyc drops.
//   - Next stb at 0x100, counter=0.
// - err on 0x104:
//   - push data 0; next adr 0x108.
//   - rty on 0x108 for 2 cycles: no push, adr held, then acked normally.
// - sys_rst asserted mid-READ:
//   - cyc/stb/wfifo_write=0 asynchronously.
//   - After release, restart at 0x100.
// - WSHB_BURST_EN, BURST_LEN=4:
//   - cti 010,010,010,111 for 0x100..0x10C, then a new burst.
//   - afull mid-burst: next word has cti=111.

Source files
------------

// File: rtl/fb_sdram_reader.sv
// Wishbone read master that streams a linear framebuffer into the video pixel FIFO.
// Define WSHB_BURST_EN for incrementing bursts (cti 010/111); otherwise classic cycles.
module fb_sdram_reader #(
    parameter int unsigned HDISP     = 800,
    parameter int unsigned VDISP     = 480,
    parameter logic [31:0] BASE_ADR  = 32'h0,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        frame_restart,
    input  logic        wfifo_afull,
    output logic        wfifo_write,
    output logic [31:0] wfifo_data,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_sm,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_rty,
    output logic        frame_done
);

    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    if (BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst_len
        $error("BURST_LEN must be a power of 2 and at least 2");
    end

    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nxt;

    logic [CW-1:0] counter;
    logic          restart_pend;
    logic          done_word;
    logic          term;
    logic          stop_req;
    logic          frame_end;

    assign done_word = wb_ack | wb_err;
    assign term      = done_word | wb_rty;
    assign stop_req  = wfifo_afull | restart_pend | frame_restart;
    assign frame_end = (counter == LAST);

    assign wb_we  = 1'b0;
    assign wb_sel = 4'hF;
    assign wb_bte = 2'b00;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // afull and restart are only honoured at a termination so stb never drops mid-transfer
    always_comb begin
        state_nxt = state;
        wb_cyc    = 1'b0;
        wb_stb    = 1'b0;
        case (state)
            IDLE: if (!wfifo_afull) state_nxt = READ;
            READ: begin
                wb_cyc = 1'b1;
                wb_stb = 1'b1;
                if (term && stop_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wb_adr       <= BASE_ADR;
            counter      <= '0;
            restart_pend <= 1'b0;
            wfifo_write  <= 1'b0;
            wfifo_data   <= '0;
            frame_done   <= 1'b0;
        end else begin
            wfifo_write <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart_pend || frame_restart) begin
                        wb_adr       <= BASE_ADR;
                        counter      <= '0;
                        restart_pend <= 1'b0;
                    end
                end
                READ: begin
                    if (frame_restart) restart_pend <= 1'b1;
                    if (done_word) begin
                        // an errored word still occupies its slot so the display stays aligned
                        wfifo_write <= 1'b1;
                        wfifo_data  <= wb_ack ? wb_dat_sm : '0;
                        if (frame_end) begin
                            wb_adr     <= BASE_ADR;
                            counter    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            wb_adr  <= wb_adr + 32'd4;
                            counter <= counter + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WSHB_BURST_EN
    localparam int unsigned BW = $clog2(BURST_LEN);

    logic [BW-1:0] burst_cnt;
    logic          stop_seen;
    logic          burst_cut;
    logic          burst_last;

    // burst_cut is fixed when a word is issued, keeping cti stable for the whole transfer
    assign burst_last = (burst_cnt == BW'(BURST_LEN - 1)) || frame_end || burst_cut;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            burst_cnt <= '0;
            stop_seen <= 1'b0;
            burst_cut <= 1'b0;
        end else if (state != READ || (term && stop_req)) begin
            burst_cnt <= '0;
            stop_seen <= 1'b0;
            burst_cut <= 1'b0;
        end else if (done_word) begin
            if (burst_last) begin
                burst_cnt <= '0;
                burst_cut <= 1'b0;
            end else begin
                burst_cnt <= burst_cnt + BW'(1);
                burst_cut <= stop_seen;
            end
            stop_seen <= 1'b0;
        end else begin
            stop_seen <= stop_seen | wfifo_afull | frame_restart;
        end
    end

    always_comb begin
        wb_cti = 3'b000;
        if (state == READ) wb_cti = burst_last ? 3'b111 : 3'b010;
    end
`else
    assign wb_cti = 3'b000;
`endif

endmodule
